blake2_msg_sched: RTL and testbench

//  Sequencer in front of the blake2 core. Accepts a byte stream (valid/ready) plus a
//  per-message start with kk/nn. Slices the stream into BLOCK_B-byte blocks, zero-pads
//  the final block and drives the core's data_v/data_idx/block_first/block_last/ll inputs.

---
 rtl/blake2_msg_sched.sv | 190 +++++++++++++++++++
 tb/tb_blake2_msg_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2_msg_sched.sv
// ---------------------------------------------------------------------------
// blake2_msg_sched
//
// Purpose:
//   Sits in front of the blake2 compression core. It takes a message byte
//   stream (valid/ready) and cuts it into BLOCK_B-byte blocks. It zero-pads
//   the final block and drives the core's byte-wise data interface. It waits
//   out the core's F computation between blocks. It trims the core's digest
//   byte stream to exactly nn bytes.
//
// Ports:
//   clk, reset                clock (rising edge), async active-high reset
//   start_i, empty_i          begin a message (IDLE only); empty_i = zero bytes
//   kk_i, nn_i                key / digest length, latched on start
//   s_valid_i, s_data_i,      message byte stream in
//   s_last_i, s_ready_o
//   data_v_o, data_idx_o,     byte-wise block data to the core
//   data_o, block_first_o,
//   block_last_o
//   ll_o, kk_o, nn_o          running byte count and latched kk/nn to the core
//   h_v_i, h_i                digest byte stream from the core
//   res_valid_o, res_data_o,  trimmed digest stream out
//   res_last_o
//   busy_o                    high whenever a message is in flight
// ---------------------------------------------------------------------------
module blake2_msg_sched #(
    parameter int BLOCK_B = 64,
    parameter int R       = 12,
    parameter int F_GAP   = 8*R+1,
    parameter int LL_W    = 128,
    parameter int KN_W    = 7,
    localparam int IDX_W  = $clog2(BLOCK_B),
    localparam int GAP_W  = $clog2(F_GAP+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              empty_i,
    input  logic [KN_W-1:0]   kk_i,
    input  logic [KN_W-1:0]   nn_i,
    input  logic              s_valid_i,
    input  logic [7:0]        s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic              data_v_o,
    output logic [IDX_W-1:0]  data_idx_o,
    output logic [7:0]        data_o,
    output logic              block_first_o,
    output logic              block_last_o,
    output logic [LL_W-1:0]   ll_o,
    output logic [KN_W-1:0]   kk_o,
    output logic [KN_W-1:0]   nn_o,
    input  logic              h_v_i,
    input  logic [7:0]        h_i,
    output logic              res_valid_o,
    output logic [7:0]        res_data_o,
    output logic              res_last_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_PAD,
        S_WAIT_F,
        S_WAIT_RES
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [LL_W-1:0]   r_ll;
    logic [KN_W-1:0]   r_kk;
    logic [KN_W-1:0]   r_nn;
    logic [KN_W-1:0]   r_resCnt;
    logic [GAP_W-1:0]  r_gap;
    logic              r_first;
    logic              r_last;
    logic              r_resDone;

    logic              w_accept;
    logic              w_pad;
    logic              w_idxMax;
    logic              w_resFwd;
    logic              w_resLast;
    logic [IDX_W-1:0]  w_idxNext;

    assign w_accept  = (r_state == S_STREAM) && s_valid_i;
    assign w_pad     = (r_state == S_PAD);
    assign w_idxMax  = (r_idx == IDX_W'(BLOCK_B-1));
    assign w_idxNext = w_idxMax ? '0 : IDX_W'(r_idx + 1'b1);

    // Once the nn-th digest byte has gone out, further core bytes are swallowed.
    assign w_resFwd  = (r_state == S_WAIT_RES) && h_v_i && !r_resDone;
    assign w_resLast = w_resFwd && (KN_W'(r_resCnt + 1'b1) == r_nn);

    // Message bytes are passed through combinationally so an accepted byte
    // reaches the core in the same cycle it is taken from the stream.
    assign s_ready_o     = (r_state == S_STREAM);
    assign data_v_o      = w_accept || w_pad;
    assign data_o        = w_accept ? s_data_i : 8'h00;
    assign data_idx_o    = r_idx;
    assign block_first_o = data_v_o && r_first;
    assign block_last_o  = w_pad || (w_accept && s_last_i);
    assign ll_o          = r_ll;
    assign kk_o          = r_kk;
    assign nn_o          = r_nn;
    assign res_valid_o   = w_resFwd;
    assign res_data_o    = w_resFwd ? h_i : 8'h00;
    assign res_last_o    = w_resLast;
    assign busy_o        = (r_state != S_IDLE);

    // Main sequencer. r_last marks that the block being built is the final
    // one. The WAIT_F exit then either goes to the digest phase or holds the
    // stream off for F_GAP cycles while the core computes F.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_ll      <= '0;
            r_kk      <= '0;
            r_nn      <= '0;
            r_resCnt  <= '0;
            r_gap     <= '0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_resDone <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_kk      <= kk_i;
                        r_nn      <= nn_i;
                        r_ll      <= '0;
                        r_idx     <= '0;
                        r_first   <= 1'b1;
                        r_last    <= empty_i;
                        r_resCnt  <= '0;
                        r_resDone <= 1'b0;
                        r_gap     <= '0;
                        r_state   <= empty_i ? S_PAD : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (s_valid_i) begin
                        r_ll  <= r_ll + 1'b1;
                        r_idx <= w_idxNext;
                        if (s_last_i) begin
                            r_last  <= 1'b1;
                            r_state <= w_idxMax ? S_WAIT_F : S_PAD;
                        end else if (w_idxMax) begin
                            r_state <= S_WAIT_F;
                        end
                    end
                end
                S_PAD: begin
                    r_idx <= w_idxNext;
                    if (w_idxMax) begin
                        r_state <= S_WAIT_F;
                    end
                end
                S_WAIT_F: begin
                    if (r_last) begin
                        r_state <= S_WAIT_RES;
                    end else begin
                        r_first <= 1'b0;
                        if (r_gap == GAP_W'(F_GAP-1)) begin
                            r_gap   <= '0;
                            r_state <= S_STREAM;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                end
                S_WAIT_RES: begin
                    if (w_resFwd) begin
                        r_resCnt <= r_resCnt + 1'b1;
                        if (w_resLast) begin
                            r_resDone <= 1'b1;
                        end
                    end
                    if (r_resDone && !h_v_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2_msg_sched.sv
// ---------------------------------------------------------------------------
// tb_blake2_msg_sched
//
// Purpose:
//   Testbench for blake2_msg_sched. A table of message descriptors is run
//   through the scheduler. The bench stands in for the blake2 core: it
//   supplies an nn+1 byte digest pattern. A negedge monitor captures the
//   core-side byte stream, the F gaps and the trimmed digest. These are
//   compared against a small model of padded block layout. Hand-written
//   sequences cover the reset state and a reset asserted during padding.
// ---------------------------------------------------------------------------
module tb_blake2_msg_sched;

    localparam int BLOCK_B = 64;
    localparam int F_GAP   = 97;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i, empty_i;
    logic [6:0]   kk_i, nn_i;
    logic         s_valid_i, s_last_i;
    logic [7:0]   s_data_i;
    logic         s_ready_o;
    logic         data_v_o;
    logic [5:0]   data_idx_o;
    logic [7:0]   data_o;
    logic         block_first_o, block_last_o;
    logic [127:0] ll_o;
    logic [6:0]   kk_o, nn_o;
    logic         h_v_i;
    logic [7:0]   h_i;
    logic         res_valid_o;
    logic [7:0]   res_data_o;
    logic         res_last_o;
    logic         busy_o;

    blake2_msg_sched dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .empty_i       (empty_i),
        .kk_i          (kk_i),
        .nn_i          (nn_i),
        .s_valid_i     (s_valid_i),
        .s_data_i      (s_data_i),
        .s_last_i      (s_last_i),
        .s_ready_o     (s_ready_o),
        .data_v_o      (data_v_o),
        .data_idx_o    (data_idx_o),
        .data_o        (data_o),
        .block_first_o (block_first_o),
        .block_last_o  (block_last_o),
        .ll_o          (ll_o),
        .kk_o          (kk_o),
        .nn_o          (nn_o),
        .h_v_i         (h_v_i),
        .h_i           (h_i),
        .res_valid_o   (res_valid_o),
        .res_data_o    (res_data_o),
        .res_last_o    (res_last_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           len;
        bit           empty;
        logic [6:0]   kk;
        logic [6:0]   nn;
        bit           gaps;
        bit           noisyStarts;
        logic [127:0] expLl;
        int           expBlocks;
    } vec_t;

    vec_t vecs[5];

    int nCompared   = 0;
    int nMismatched = 0;

    // Capture of everything the scheduler hands to the core and back out.
    logic [7:0] capData[$];
    int         capIdx[$];
    bit         capFirst[$];
    bit         capLast[$];
    logic [7:0] capRes[$];
    bit         capResLast[$];
    int         gapQ[$];
    bit         finalSeen;
    bit         gapArm;
    int         gapCnt;

    // Sample on the falling edge so combinational outputs have settled. A
    // non-final idx 63 arms a counter measuring how long s_ready_o stays low.
    always @(negedge clk) begin
        if (!reset) begin
            if (gapArm) begin
                if (s_ready_o) begin
                    gapQ.push_back(gapCnt);
                    gapArm = 1'b0;
                end else begin
                    gapCnt++;
                end
            end
            if (data_v_o) begin
                capData.push_back(data_o);
                capIdx.push_back(int'(data_idx_o));
                capFirst.push_back(block_first_o);
                capLast.push_back(block_last_o);
                if (data_idx_o == 6'd63) begin
                    if (block_last_o) begin
                        finalSeen = 1'b1;
                    end else begin
                        gapArm = 1'b1;
                        gapCnt = 0;
                    end
                end
            end
            if (res_valid_o) begin
                capRes.push_back(res_data_o);
                capResLast.push_back(res_last_o);
            end
        end
    end

    function automatic logic [7:0] genByte(int len, int i);
        if (len == 3) return 8'(8'h61 + i);
        return 8'(i*37 + 11);
    endfunction

    function automatic logic [7:0] hByte(int k, int j);
        return 8'(j*13 + k*29 + 5);
    endfunction

    task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearCapture();
        capData.delete();
        capIdx.delete();
        capFirst.delete();
        capLast.delete();
        capRes.delete();
        capResLast.delete();
        gapQ.delete();
        finalSeen = 1'b0;
        gapArm    = 1'b0;
        gapCnt    = 0;
    endtask

    task automatic pulseStart(bit empty, logic [6:0] kk, logic [6:0] nn);
        start_i = 1'b1;
        empty_i = empty;
        kk_i    = kk;
        nn_i    = nn;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        empty_i = 1'b0;
    endtask

    // Stream len bytes; optionally insert idle gaps and (when noisy)
    // start_i pulses with bogus kk/nn that the busy scheduler must ignore.
    task automatic sendMessage(int k, int len, bit gaps, bit noisy);
        int waitCnt;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid_i = 1'b0;
                if (noisy) begin
                    start_i = 1'b1;
                    empty_i = 1'b1;
                    kk_i    = 7'h55;
                    nn_i    = 7'h11;
                end
                @(posedge clk);
                #1;
                start_i = 1'b0;
                empty_i = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            s_valid_i = 1'b1;
            s_data_i  = genByte(len, i);
            s_last_i  = (i == len-1);
            waitCnt   = 0;
            do begin
                @(negedge clk);
                waitCnt++;
            end while (!s_ready_o && waitCnt < 500);
            if (!s_ready_o) begin
                checkOutput($sformatf("v%0d ready timeout byte %0d", k, i), 0, 1);
                s_valid_i = 1'b0;
                s_last_i  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    // Play the core's digest output: nn+1 bytes, the extra one must be dropped.
    task automatic playDigest(int k, int nn);
        for (int j = 0; j <= nn; j++) begin
            h_v_i = 1'b1;
            h_i   = hByte(k, j);
            @(posedge clk);
            #1;
        end
        h_v_i = 1'b0;
        h_i   = 8'h00;
    endtask

    task automatic applyStimulus(int k);
        vec_t v;
        int   cnt;
        int   errs;
        int   firstBad;
        int   nBytes;
        v = vecs[k];
        clearCapture();
        pulseStart(v.empty, v.kk, v.nn);
        if (!v.empty) sendMessage(k, v.len, v.gaps, v.noisyStarts);

        cnt = 0;
        while (!finalSeen && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput($sformatf("v%0d final block seen", k), 128'(finalSeen), 1);
        repeat (4) @(posedge clk);
        #1;
        playDigest(k, int'(v.nn));
        cnt = 0;
        while (busy_o && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput($sformatf("v%0d busy falls", k), 128'(busy_o), 0);

        nBytes = v.expBlocks * BLOCK_B;
        checkOutput($sformatf("v%0d core byte count", k), 128'(capData.size()), 128'(nBytes));
        errs = 0;
        firstBad = -1;
        for (int i = 0; i < capData.size() && i < nBytes; i++) begin
            logic [7:0] eData;
            bit         eFirst;
            bit         eLast;
            eData  = (i < v.len) ? genByte(v.len, i) : 8'h00;
            eFirst = (i < BLOCK_B);
            eLast  = (i + 1 >= v.len);
            if (capData[i] !== eData || capIdx[i] != i % BLOCK_B ||
                capFirst[i] != eFirst || capLast[i] != eLast) begin
                errs++;
                if (firstBad < 0) firstBad = i;
            end
        end
        checkOutput($sformatf("v%0d core stream errors (first at %0d)", k, firstBad), 128'(errs), 0);

        checkOutput($sformatf("v%0d F gap count", k), 128'(gapQ.size()), 128'(v.expBlocks - 1));
        foreach (gapQ[g]) begin
            checkOutput($sformatf("v%0d F gap %0d length", k, g), 128'(gapQ[g]), 128'(F_GAP));
        end

        checkOutput($sformatf("v%0d ll_o", k), ll_o, v.expLl);
        checkOutput($sformatf("v%0d kk_o", k), 128'(kk_o), 128'(v.kk));
        checkOutput($sformatf("v%0d nn_o", k), 128'(nn_o), 128'(v.nn));

        checkOutput($sformatf("v%0d digest byte count", k), 128'(capRes.size()), 128'(v.nn));
        errs = 0;
        firstBad = -1;
        for (int j = 0; j < capRes.size(); j++) begin
            if (capRes[j] !== hByte(k, j) || capResLast[j] != (j == int'(v.nn) - 1)) begin
                errs++;
                if (firstBad < 0) firstBad = j;
            end
        end
        checkOutput($sformatf("v%0d digest errors (first at %0d)", k, firstBad), 128'(errs), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        start_i   = 1'b0;
        empty_i   = 1'b0;
        kk_i      = '0;
        nn_i      = '0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
        h_v_i     = 1'b0;
        h_i       = '0;

        //        len empty kk     nn      gaps noisy ll      blocks
        vecs[0] = '{3,   0, 7'd0,  7'd32,  0,   0,    128'd3,   1};
        vecs[1] = '{64,  0, 7'd0,  7'd64,  0,   0,    128'd64,  1};
        vecs[2] = '{65,  0, 7'd5,  7'd32,  0,   0,    128'd65,  2};
        vecs[3] = '{0,   1, 7'd0,  7'd32,  0,   0,    128'd0,   1};
        vecs[4] = '{130, 0, 7'd3,  7'd20,  1,   1,    128'd130, 3};

        clearCapture();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy_o", 128'(busy_o), 0);
        checkOutput("reset s_ready_o", 128'(s_ready_o), 0);
        checkOutput("reset data_v_o", 128'(data_v_o), 0);
        checkOutput("reset ll_o", ll_o, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 5; k++) begin
            applyStimulus(k);
        end

        // Abandon a message mid-padding; everything must drop to zero at once.
        clearCapture();
        pulseStart(1'b0, 7'd9, 7'd16);
        sendMessage(9, 3, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("pad before reset data_v_o", 128'(data_v_o), 1);
        reset = 1'b1;
        #1;
        checkOutput("async reset outputs",
                    128'({data_v_o, s_ready_o, busy_o, block_last_o, block_first_o,
                          res_valid_o, |ll_o, |kk_o, |nn_o, |data_idx_o, |data_o}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
